// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked arbiter sharing one UART transmitter; optional stall timeout under UART_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  input  logic [NUM_SRC*DATA_BITS-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]           s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [DATA_BITS-1:0]         m_axis_tdata,
  output logic                         grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         timeout_pulse
);
  localparam int IW = $clog2(NUM_SRC);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [IW-1:0] grant_nx, pick, idx;
  logic g_valid, g_last, expire;

  if (NUM_SRC < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_SRC and TIMEOUT_CYCLES must both be >= 2");
  end

  // Search upward from the last grant; the last winner is visited last so it ends up lowest priority
  always_comb begin
    pick = grant_idx;
    idx = grant_idx;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = IW'((int'(grant_idx) + k) % NUM_SRC);
      if (s_axis_tvalid[idx]) pick = idx;
    end
  end

  // Zero-latency pass-through of the granted source; everyone else sees no ready
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata = '0;
    g_valid = 1'b0;
    g_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (IW'(i) == grant_idx) begin
        m_axis_tdata = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
        g_valid = s_axis_tvalid[i];
        g_last = s_axis_tlast[i];
        s_axis_tready[i] = (state == LOCKED) && m_axis_tready;
      end
  end

  assign grant_valid = state == LOCKED;
  assign m_axis_tvalid = grant_valid && g_valid;

  // Lock onto the selected source, release on its tlast handshake or a stall timeout
  always_comb begin
    state_nx = state == IDLE ? (|s_axis_tvalid ? LOCKED : IDLE)
                             : ((g_valid && m_axis_tready && g_last) || expire ? IDLE : LOCKED);
    grant_nx = (state == IDLE && |s_axis_tvalid) ? pick : grant_idx;
  end

  // State and grant registers; reset aims the grant at the last source so source 0 wins first
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state <= IDLE;
      grant_idx <= IW'(NUM_SRC - 1);
    end else begin
      state <= state_nx;
      grant_idx <= grant_nx;
    end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] stall_cnt;
  assign expire = (state == LOCKED) && !g_valid && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_pulse = expire;

  // Count idle cycles of the granted source; any valid, a release, or being outside LOCKED clears it
  always_ff @(posedge clk or posedge areset)
    if (areset) stall_cnt <= '0;
    else stall_cnt <= (state != LOCKED || g_valid || expire) ? '0 : stall_cnt + 1'b1;
`else
  assign expire = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a message-level model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic areset;
  logic [N-1:0] s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*8-1:0] s_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, grant_valid, timeout_pulse;
  logic [7:0] m_axis_tdata;
  logic [1:0] grant_idx;
  int total = 0;
  int bad = 0;
  logic [7:0] md [N][64];
  bit ml [N][64];
  int len [N];
  int pos [N];
  int log_s[$];
  int log_b[$];
  int log_c[$];
  int cyc, last_owner, owner, n, pulses, nbytes;
  bit gv_exp, hit;
  int lock_exp [6] = '{'h11, 'h12, 'h13, 'h21, 'h22, 'h23};

  uart_tx_arbiter #(.NUM_SRC(N), .DATA_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    s_axis_tlast = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    log_s.delete();
    log_b.delete();
    log_c.delete();
    last_owner = N - 1;
    owner = 0;
    gv_exp = 1'b0;
  endtask

  task automatic add_msg(input int s, input int cnt, input logic [7:0] b0, input bit rnd);
    for (int j = 0; j < cnt; j++) begin
      md[s][len[s]] = rnd ? 8'($urandom) : b0 + 8'(j);
      ml[s][len[s]] = (j == cnt - 1);
      len[s]++;
    end
  endtask

  function automatic int pick_next();
    for (int k = 1; k <= N; k++) begin
      int s = (last_owner + k) % N;
      if (pos[s] < len[s]) return s;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i] = pos[i] < len[i];
      s_axis_tdata[i*8 +: 8] = (pos[i] < len[i]) ? md[i][pos[i]] : 8'h00;
      s_axis_tlast[i] = (pos[i] < len[i]) && ml[i][pos[i]];
    end
  endtask

  task automatic observe();
    bit pend = 1'b0;
    for (int i = 0; i < N; i++) if (pos[i] < len[i]) pend = 1'b1;
    chk("grant_valid", grant_valid, gv_exp);
    chk("timeout_pulse", timeout_pulse, 0);
    if (gv_exp) begin
      chk("grant_idx", grant_idx, owner);
      chk("m_tvalid", m_axis_tvalid, 1);
      chk("m_tdata", m_axis_tdata, md[owner][pos[owner]]);
      chk("s_tready", s_axis_tready, m_axis_tready ? 4'(1 << owner) : 4'b0);
      if (m_axis_tready) begin
        log_s.push_back(owner);
        log_b.push_back(int'(md[owner][pos[owner]]));
        log_c.push_back(cyc);
        if (ml[owner][pos[owner]]) begin
          gv_exp = 1'b0;
          last_owner = owner;
        end
        pos[owner]++;
      end
    end else begin
      chk("idle_grant_idx", grant_idx, last_owner);
      chk("idle_m_tvalid", m_axis_tvalid, 0);
      chk("idle_s_tready", s_axis_tready, 0);
      if (pend) begin
        owner = pick_next();
        gv_exp = 1'b1;
      end
    end
  endtask

  task automatic run(input int budget, input int pct, input int sf, input int sl, input bit drain);
    int c = 0;
    bit done = 1'b0;
    while (!(drain && done) && c < budget) begin
      drive();
      m_axis_tready = (c >= sf && c < sf + sl) ? 1'b0 : ($urandom_range(99) < pct);
      @(negedge clk);
      cyc = c;
      observe();
      c++;
      done = 1'b1;
      for (int i = 0; i < N; i++) if (pos[i] < len[i]) done = 1'b0;
      @(posedge clk);
      #1;
    end
    if (drain) chk("drain", done, 1);
  endtask

  initial begin
    areset = 1'b1;
    s_axis_tvalid = '1;
    s_axis_tlast = '1;
    s_axis_tdata = 32'h44332211;
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_grant_idx", grant_idx, N - 1);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_timeout", timeout_pulse, 0);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("rel_idle", grant_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rel_grant_valid", grant_valid, 1);
    chk("rel_grant_idx", grant_idx, 0);

    do_reset();
    add_msg(1, 3, 8'h11, 1'b0);
    add_msg(2, 3, 8'h21, 1'b0);
    run(50, 100, 0, 0, 1'b1);
    chk("lock_count", log_b.size(), 6);
    for (int i = 0; i < 6 && i < log_b.size(); i++) chk("lock_byte", log_b[i], lock_exp[i]);
    if (log_c.size() >= 4) begin
      chk("lock_first_cycle", log_c[0], 1);
      chk("lock_bubble", log_c[3] - log_c[2], 2);
    end

    do_reset();
    for (int i = 0; i < N; i++) begin
      add_msg(i, 1, 8'(16 * i), 1'b0);
      add_msg(i, 1, 8'(16 * i + 1), 1'b0);
    end
    run(100, 100, 0, 0, 1'b1);
    chk("rr_count", log_s.size(), 8);
    for (int i = 0; i < 8 && i < log_s.size(); i++) chk("rr_order", log_s[i], i % N);
    for (int i = 0; i < 7 && i + 1 < log_c.size(); i++) chk("rr_period", log_c[i+1] - log_c[i], 2);

    do_reset();
    add_msg(0, 5, 8'h50, 1'b0);
    run(100, 100, 3, 10, 1'b1);
    chk("bp_count", log_b.size(), 5);
    for (int i = 0; i < 5 && i < log_b.size(); i++) chk("bp_byte", log_b[i], 'h50 + i);
    if (log_c.size() >= 3) chk("bp_gap", log_c[2] - log_c[1], 11);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      nbytes = 0;
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 5);
        for (int m = 0; m < n; m++) add_msg(i, $urandom_range(1, 4), 8'h00, 1'b1);
        nbytes += len[i];
      end
      run(3000, 60, 0, 0, 1'b1);
      chk("rand_bytes", log_b.size(), nbytes);
    end

    do_reset();
    add_msg(2, 4, 8'h40, 1'b0);
    run(3, 100, 0, 0, 1'b0);
    drive();
    #1;
    chk("ar_pre_m_tvalid", m_axis_tvalid, 1);
    chk("ar_pre_s_tready", s_axis_tready, 4'b0100);
    areset = 1'b1;
    #1;
    chk("ar_s_tready", s_axis_tready, 0);
    chk("ar_m_tvalid", m_axis_tvalid, 0);
    chk("ar_grant_valid", grant_valid, 0);
    do_reset();
    add_msg(1, 1, 8'h61, 1'b0);
    add_msg(2, 1, 8'h62, 1'b0);
    add_msg(0, 1, 8'h60, 1'b0);
    run(50, 100, 0, 0, 1'b1);
    chk("ar_count", log_s.size(), 3);
    for (int i = 0; i < 3 && i < log_s.size(); i++) chk("ar_order", log_s[i], i);

    do_reset();
    s_axis_tvalid = 4'b1001;
    s_axis_tdata = 32'h3C0000A5;
    s_axis_tlast = 4'b1000;
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("to_idle", grant_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("to_grant_valid", grant_valid, 1);
    chk("to_grant_idx", grant_idx, 0);
    chk("to_m_tdata", m_axis_tdata, 8'hA5);
    @(posedge clk);
    #1 s_axis_tvalid[0] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      hit = timeout_pulse;
      if (!hit) begin
        @(posedge clk);
        #1;
      end
    end
    chk("to_fired", hit, 1);
    chk("to_stall_cycles", n, 16);
    chk("to_m_tvalid", m_axis_tvalid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("to_released", grant_valid, 0);
    chk("to_pulse_width", timeout_pulse, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("to_next_valid", grant_valid, 1);
    chk("to_next_idx", grant_idx, 3);
    chk("to_next_data", m_axis_tdata, 8'h3C);
`else
    pulses = 0;
    repeat (1000) begin
      @(negedge clk);
      pulses += int'(timeout_pulse);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("hold_pulses", pulses, 0);
    chk("hold_grant_valid", grant_valid, 1);
    chk("hold_grant_idx", grant_idx, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, message-locked arbiter that shares one UART transmitter between `NUM_SRC` AXI-Stream byte sources. It sits directly upstream of the UART transmitter's `s_axis` port. Each grant is held until the granted source completes a message with `tlast`, so bytes from different sources never interleave on the serial line. An optional timeout releases a grant whose source stalls mid-message.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources; must be ≥ 2.
- `DATA_BITS`, 8: byte width; must match the transmitter.
- `TIMEOUT_CYCLES`, 1000000: stall limit in clk cycles; used only when `UART_ARB_TIMEOUT_EN` is defined; must be ≥ 2.

Ports:
- `clk`  in  1  single clock domain.
- `areset`  in  1  reset; asynchronous, active-high.
- `s_axis_tvalid`  in  NUM_SRC  per-source valid; bit i belongs to source i.
- `s_axis_tready`  out  NUM_SRC  per-source ready.
- `s_axis_tdata`  in  NUM_SRC*DATA_BITS  source i occupies bits [i*DATA_BITS +: DATA_BITS].
- `s_axis_tlast`  in  NUM_SRC  end-of-message marker, per source.
- `m_axis_tvalid`  out  1  to the transmitter's `s_axis_tvalid`.
- `m_axis_tready`  in  1  from the transmitter's `s_axis_tready`.
- `m_axis_tdata`  out  DATA_BITS  to the transmitter's `s_axis_tdata`.
- `grant_valid`  out  1  high while in the LOCKED state.
- `grant_idx`  out  $clog2(NUM_SRC)  index of the current or most recent grant.
- `timeout_pulse`  out  1  one-cycle pulse when a grant is force-released; tied to 0 without the macro.

## Operation
- State machine with two states: IDLE and LOCKED. Registers: `state`, `grant_idx`, and a stall counter (only when the macro is defined).
- IDLE behaviour:
  - All `s_axis_tready` = 0; `m_axis_tvalid` = 0.
  - If any `s_axis_tvalid` bit is high, select the first set bit searching upward from `grant_idx+1`, wrapping from NUM_SRC-1 to 0.
  - Register the selected index into `grant_idx` and go to LOCKED.
  - `grant_idx` itself is searched last, so a requester that just finished has the lowest priority.
- LOCKED behaviour, with g = `grant_idx`:
  - Combinational pass-through: `m_axis_tvalid` = `s_axis_tvalid[g]`, `m_axis_tdata` = source g's data, `s_axis_tready[g]` = `m_axis_tready`.
  - All other `s_axis_tready` bits = 0.
- Release: a handshake on source g (`s_axis_tvalid[g] && m_axis_tready`) with `s_axis_tlast[g]` = 1 returns the block to IDLE in the next cycle.
- `tlast` is not forwarded; the transmitter has no `tlast` input.
- Non-granted sources may assert or deassert `tvalid` freely. They are never acknowledged while another source holds the grant.

## Timing
- Reset values: state IDLE; `grant_idx` = NUM_SRC-1, so source 0 wins the first arbitration; `s_axis_tready` = 0; `m_axis_tvalid` = 0; `grant_valid` = 0; `timeout_pulse` = 0; stall counter = 0.
- `m_axis_tdata` is don't-care while `m_axis_tvalid` = 0.
- Arbitration latency:
  - A request seen in IDLE at cycle N gives `grant_valid` = 1 at cycle N+1.
  - The first byte can transfer at cycle N+1.
- The data path adds zero cycles of latency and applies no buffering.
- There is exactly one IDLE bubble cycle between consecutive messages, including back-to-back messages from the same source.
- A single-byte message (tlast on the first byte) is legal: LOCKED lasts one cycle if `m_axis_tready` is high.
- Reset asserted mid-message: the grant is dropped immediately and asynchronously. The interrupted message is truncated; the transmitter finishes any byte already accepted.
- Simultaneous requests from all sources: service order is strictly round-robin, 0,1,2,3,0,…

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined:
  - In LOCKED, the stall counter increments each cycle that `s_axis_tvalid[g]` = 0.
  - Any cycle with `s_axis_tvalid[g]` = 1 clears the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low, the block goes to IDLE, pulses `timeout_pulse` for one cycle and clears the counter.
  - `grant_idx` keeps g, so the stalled source drops to the lowest priority.
  - The counter never releases a grant while `m_axis_tvalid` = 1, so the AXI valid-stability rule holds.
  - The counter is cleared on entry to LOCKED.
- Not defined: no counter is built; a grant is held indefinitely until `tlast`; `timeout_pulse` is constant 0.

## Test plan
- **Reset state.** Assert `areset`, drive all sources valid → all `s_axis_tready` = 0, `m_axis_tvalid` = 0, `grant_idx` = NUM_SRC-1. After release, the first grant goes to source 0 with `grant_valid` = 1 one cycle later.
- **Message locking.** Sources 1 and 2 each send a 3-byte message (0x11,0x12,0x13 and 0x21,0x22,0x23) with `m_axis_tready` = 1 → output is 0x11,0x12,0x13, one bubble, 0x21,0x22,0x23. Source 2 sees no ready while source 1 holds the grant.
- **Round-robin fairness.** All four sources hold continuous 1-byte messages → grant order 0,1,2,3,0,1,2,3 with a 2-cycle period per grant.
- **Backpressure.** Hold `m_axis_tready` = 0 for 10 cycles mid-message → `m_axis_tvalid` and `m_axis_tdata` stay stable, the grant does not change, and no byte is lost or duplicated.
- **Timeout.** With `UART_ARB_TIMEOUT_EN` defined and TIMEOUT_CYCLES = 16, source 0 sends 1 byte without tlast and then idles → `timeout_pulse` fires after 16 stall cycles and the next grant goes to waiting source 3. Without the macro, the grant is still held after 1000 cycles.
- **Async reset mid-message.** Assert `areset` between clock edges during LOCKED → `s_axis_tready` and `m_axis_tvalid` fall before the next edge. After release, arbitration restarts from source 0.
